// File: rtl/quad_decoder_if.sv
// Signal bundle between a quadrature decoder and its environment: filtered
// encoder channels with filter status in, position/step/fault reporting out.
interface quad_decoder_if #(
  parameter int CNT_WIDTH     = 32,
  parameter int ERR_CNT_WIDTH = 8
);
  logic                     a_in;
  logic                     b_in;
  logic                     a_ready;
  logic                     b_ready;
  logic                     a_timeout;
  logic                     b_timeout;
  logic                     load;
  logic [CNT_WIDTH-1:0]     load_value;
  logic                     err_clr;
  logic [CNT_WIDTH-1:0]     pos;
  logic                     step;
  logic                     dir;
  logic                     valid;
  logic                     err_seq;
  logic                     err_stuck;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  modport master (
    output a_in, b_in, a_ready, b_ready, a_timeout, b_timeout,
    output load, load_value, err_clr,
    input  pos, step, dir, valid, err_seq, err_stuck, err_cnt
  );

  modport slave (
    input  a_in, b_in, a_ready, b_ready, a_timeout, b_timeout,
    input  load, load_value, err_clr,
    output pos, step, dir, valid, err_seq, err_stuck, err_cnt
  );
endinterface

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: signed wrapping position, per-edge step/dir pulse,
// sticky sequence/stuck faults and a saturating illegal-transition counter.
module quad_decoder #(
  parameter int CNT_WIDTH     = 32,
  parameter int ERR_CNT_WIDTH = 8,
  parameter bit DIR_INVERT    = 1'b0
) (
  input  logic           clock,
  input  logic           sclr,
  quad_decoder_if.slave  bus
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               prev_q, prev_d;
  logic [CNT_WIDTH-1:0]     pos_q, pos_d;
  logic                     step_q, step_d;
  logic                     dir_q, dir_d;
  logic                     err_seq_q, err_seq_d;
  logic                     err_stuck_q, err_stuck_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic [1:0] cur;
  logic       both_ready;
  logic       mv_up, mv_dn, mv_bad;
  logic       cnt_up, cnt_dn;
  logic       stuck_evt;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    pos_d       = pos_q;
    step_d      = 1'b0;
    dir_d       = dir_q;
    err_seq_d   = err_seq_q;
    err_stuck_d = err_stuck_q;
    err_cnt_d   = err_cnt_q;
    mv_up       = 1'b0;
    mv_dn       = 1'b0;
    mv_bad      = 1'b0;
    cur         = {bus.a_in, bus.b_in};
    both_ready  = bus.a_ready && bus.b_ready;

    case (state_q)
      ST_INIT: begin
        // The entry sample only seeds prev; it never produces a count.
        if (both_ready) begin
          prev_d  = cur;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!both_ready) begin
          state_d = ST_INIT;
        end else begin
          prev_d = cur;
          case ({prev_q, cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: mv_up  = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: mv_dn  = 1'b1;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: mv_bad = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_d = ST_INIT;
    endcase

    stuck_evt = (state_q == ST_RUN) && (bus.a_timeout || bus.b_timeout);
    cnt_up    = DIR_INVERT ? mv_dn : mv_up;
    cnt_dn    = DIR_INVERT ? mv_up : mv_dn;

    // A load swallows a same-cycle edge entirely (prev still advances above).
    if (bus.load) begin
      pos_d = bus.load_value;
    end else if (cnt_up) begin
      pos_d  = pos_q + CNT_WIDTH'(1);
      step_d = 1'b1;
      dir_d  = 1'b1;
    end else if (cnt_dn) begin
      pos_d  = pos_q - CNT_WIDTH'(1);
      step_d = 1'b1;
      dir_d  = 1'b0;
    end

    if (bus.err_clr) begin
      err_seq_d   = mv_bad;
      err_stuck_d = stuck_evt;
      err_cnt_d   = mv_bad ? ERR_CNT_WIDTH'(1) : '0;
    end else begin
      err_seq_d   = err_seq_q | mv_bad;
      err_stuck_d = err_stuck_q | stuck_evt;
      if (mv_bad && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
        err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q     <= ST_INIT;
      prev_q      <= 2'b00;
      pos_q       <= '0;
      step_q      <= 1'b0;
      dir_q       <= 1'b1;
      err_seq_q   <= 1'b0;
      err_stuck_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      pos_q       <= pos_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      err_seq_q   <= err_seq_d;
      err_stuck_q <= err_stuck_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.pos       = pos_q;
  assign bus.step      = step_q;
  assign bus.dir       = dir_q;
  assign bus.valid     = (state_q == ST_RUN);
  assign bus.err_seq   = err_seq_q;
  assign bus.err_stuck = err_stuck_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature decoder directly downstream of two input_filter instances: consumes filtered encoder channels A and B plus each filter's ready/timeout status.
- Produces a signed x4 position count, a per-edge step pulse with direction, and sticky fault reporting.
- Used for handwheel and feedback encoders in the CNC motion path, all in the system clock domain.

Parameters:
CNT_WIDTH, 32, width of the position counter (two's complement)
ERR_CNT_WIDTH, 8, width of the saturating illegal-transition counter
DIR_INVERT, 0, 1 = swap count direction (A-leads-B counts down)

Ports:
clock  input  1  system clock; all logic on rising edge
sclr  input  1  synchronous reset, active-high
a_in  input  1  filtered channel A (filter out)
b_in  input  1  filtered channel B (filter out)
a_ready  input  1  channel A filter ready
b_ready  input  1  channel B filter ready
a_timeout  input  1  channel A filter timeout
b_timeout  input  1  channel B filter timeout
load  input  1  1-cycle strobe: load position
load_value  input  CNT_WIDTH  value written on load
err_clr  input  1  1-cycle strobe: clear error flags and err_cnt
pos  output  CNT_WIDTH  current position, signed
step  output  1  1-cycle pulse per counted edge
dir  output  1  direction of last counted edge (1 = up)
valid  output  1  decoder in RUN state
err_seq  output  1  sticky: illegal transition seen
err_stuck  output  1  sticky: filter timeout seen while in RUN
err_cnt  output  ERR_CNT_WIDTH  saturating count of illegal transitions

Behaviour:
- Reset: sclr=1 forces state=INIT, pos=0, step=0, dir=1, valid=0, err_seq=0, err_stuck=0, err_cnt=0, prev=00. sclr overrides every other input.
- FSM:
  - INIT: valid=0, no counting. When a_ready && b_ready, capture prev<={a_in,b_in} and go to RUN on the next edge. That first sample never counts.
  - RUN: valid=1. If !a_ready || !b_ready, go to INIT. pos and error flags are retained.
- Decoding in RUN: cur={a_in,b_in}, compared each cycle with prev; prev<=cur every cycle.
  - Up sequence (A leads): 00→10→11→01→00 gives +1.
  - Reverse sequence gives −1. DIR_INVERT=1 swaps the sign.
  - cur==prev: no action.
  - Both bits changed (00↔11, 10↔01): no count, err_seq<=1, err_cnt increments and saturates at all-ones.
- Latency: a cycle in which cur differs legally from prev updates pos, asserts step and updates dir on that clock edge. Outputs are visible one cycle after the input change is presented; step is high for exactly one cycle per edge.
- Arithmetic: pos wraps modulo 2^CNT_WIDTH (max+1→min, min−1→max). No saturation.
- load: pos<=load_value and has priority over a same-cycle count. That count is dropped and step stays 0, but prev is still updated so the edge is consumed. load acts in any state.
- err_stuck: set when in RUN and (a_timeout || b_timeout). Not set in INIT.
- err_clr: clears err_seq, err_stuck and err_cnt. A same-cycle error event wins: flag ends at 1, err_cnt ends at 1.
- Mid-operation sclr: immediate return to the reset values; the next RUN entry re-captures prev without counting.
- No combinational path from inputs to outputs; all outputs registered.

Test Plan:
- Reset/entry: sclr pulse, then a_ready=b_ready=1 with AB=11 → valid=1 two cycles later, pos=0, step never asserted.
- Forward/reverse: 8 up edges from 00 (00,10,11,01,00,…) → pos=8, 8 single-cycle step pulses, dir=1. Then 3 reverse edges → pos=5, dir=0. Repeat with DIR_INVERT=1 → pos=−8 then −5.
- Wrap: load load_value=0x7FFFFFFF, one up edge → pos=0x80000000. Load 0, one down edge → pos=0xFFFFFFFF.
- Illegal and saturation: jump 00→11 300 times (interleave legal returns) → pos unchanged by jumps, err_seq=1, err_cnt=255 (width 8). err_clr with simultaneous illegal jump → err_seq=1, err_cnt=1. err_clr alone → all error outputs 0.
- Load vs count collision: load=1, load_value=100 in the same cycle as a legal up edge → pos=100, step=0. Next legal up edge → pos=101.
- Ready/timeout: drop b_ready in RUN → valid=0 next cycle, pos held, edges ignored. Restore → re-entry without a count. a_timeout pulse in RUN → err_stuck=1. a_timeout in INIT → err_stuck stays 0.
